// File: rtl/seq_shift_add_mult_pkg.sv
// -----------------------------------------------------------------------------
// seq_shift_add_mult_pkg
//   Shared definitions for the sequential shift-and-add multiplier and the ALU
//   decode that hands multiply operations to it.
//
//   mult_state_t : controller state encoding (IDLE, RUN, DONE)
//   count_width  : width of the iteration counter for a given operand width
// -----------------------------------------------------------------------------
package seq_shift_add_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // The counter runs 0 .. n-1, so clog2(n) bits suffice; never narrower
    // than one bit so the smallest legal operand width still has a counter.
    function automatic int count_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/N_Bit_ADD.sv
// -----------------------------------------------------------------------------
// N_Bit_ADD
//   Ripple-carry adder, N bits wide.  The carry out of the top bit is not
//   exported: callers that need the carry widen the adder by one bit and
//   zero-extend the operands, so the sum MSB carries it.
//
//   a, b : addends (N bits)
//   cin  : carry into bit 0
//   sum  : N-bit sum
// -----------------------------------------------------------------------------
module N_Bit_ADD #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum
);

    logic [N-1:0] carry;

    assign carry[0] = cin;

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_bit
            assign sum[i] = a[i] ^ b[i] ^ carry[i];
            if (i < N - 1) begin : g_carry
                assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
            end
        end
    endgenerate

endmodule

// File: rtl/seq_shift_add_mult.sv
// -----------------------------------------------------------------------------
// seq_shift_add_mult
//   Unsigned multi-cycle shift-and-add multiplier.  Operands are captured on a
//   start strobe; one partial product is accumulated per cycle for Nsize
//   cycles, after which the 2*Nsize-bit product is registered and done pulses.
//
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   start   : request, honoured only in IDLE or DONE
//   a       : multiplicand (Nsize bits, unsigned)
//   b       : multiplier   (Nsize bits, unsigned)
//   busy    : high while iterating
//   done    : one-cycle pulse when product is updated
//   product : last completed product (2*Nsize bits)
// -----------------------------------------------------------------------------
module seq_shift_add_mult
    import seq_shift_add_mult_pkg::*;
#(
    parameter int Nsize = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [Nsize-1:0]   a,
    input  logic [Nsize-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*Nsize-1:0] product
);

    localparam int            CW         = count_width(Nsize);
    localparam logic [CW-1:0] LAST_COUNT = CW'(Nsize - 1);

    mult_state_t        state_q;
    mult_state_t        state_d;
    logic               accept;
    logic               last_iter;

    logic [Nsize-1:0]   mcand_q;
    logic [Nsize-1:0]   acc_hi_q;
    logic [Nsize-1:0]   acc_lo_q;
    logic [CW-1:0]      count_q;
    logic               busy_q;
    logic               done_q;
    logic [2*Nsize-1:0] product_q;

    logic [Nsize-1:0]   addend;
    logic [Nsize:0]     sum;

    // The multiplier bit under test is always acc_lo[0]: b is shifted out of
    // the low half as product bits are shifted in from the top.
    assign addend = acc_lo_q[0] ? mcand_q : '0;

    // One bit wider than the operands so the carry lands in sum[Nsize].
    N_Bit_ADD #(
        .N   (Nsize + 1)
    ) u_add (
        .a   ({1'b0, acc_hi_q}),
        .b   ({1'b0, addend}),
        .cin (1'b0),
        .sum (sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        last_iter = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (count_q == LAST_COUNT) begin
                    last_iter = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status flags are registered copies of the next state so busy/done have
    // no combinational path from start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state_d == RUN);
            done_q <= (state_d == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else if (accept) begin
            mcand_q  <= a;
            acc_hi_q <= '0;
            acc_lo_q <= b;
            count_q  <= '0;
        end else if (state_q == RUN) begin
            // {carry, sum, acc_lo} shifted right by one: the adder carry
            // becomes the accumulator MSB and the consumed multiplier bit
            // drops off the bottom.
            acc_hi_q <= sum[Nsize:1];
            acc_lo_q <= {sum[0], acc_lo_q[Nsize-1:1]};
            if (last_iter) begin
                product_q <= {sum, acc_lo_q[Nsize-1:1]};
            end else begin
                count_q <= count_q + CW'(1);
            end
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule
